// File: rtl/mram_device_responder_pkg.sv
// Shared definitions for the MRAM parallel-port responder: bus widths, lane indices
// and the access state encoding.
package mram_device_responder_pkg;

  localparam int MRAM_DATA_W = 16;
  localparam int MRAM_ADDR_W = 20;
  localparam int LANE_LO     = 0;
  localparam int LANE_HI     = 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DRIVE,
    WR_ACTIVE
  } state_t;

endpackage

// File: rtl/mram_device_responder_byte_array.sv
// Two byte-lane storage arrays with per-lane write strobes and an asynchronous read port.
// Deliberately has no reset: contents survive a controller reset like the real part.
module mram_device_responder_byte_array
  import mram_device_responder_pkg::*;
#(
  parameter int DEPTH_BITS = 10
) (
  input  logic                   clk,
  input  logic [DEPTH_BITS-1:0]  wr_addr,
  input  logic [1:0]             wr_lane,
  input  logic [MRAM_DATA_W-1:0] wr_data,
  input  logic [DEPTH_BITS-1:0]  rd_addr,
  output logic [MRAM_DATA_W-1:0] rd_data
);

  logic [7:0] lo_mem [0:(1<<DEPTH_BITS)-1];
  logic [7:0] hi_mem [0:(1<<DEPTH_BITS)-1];

  always_ff @(posedge clk) begin
    if (wr_lane[LANE_LO]) lo_mem[wr_addr] <= wr_data[7:0];
    if (wr_lane[LANE_HI]) hi_mem[wr_addr] <= wr_data[15:8];
  end

  assign rd_data = {hi_mem[rd_addr], lo_mem[rd_addr]};

endmodule

// File: rtl/mram_device_responder.sv
// Cycle-based stand-in for the MRAM parallel port: registered pin sampling, access FSM,
// read-latency counter, per-lane tristate driver and a sticky timing-error flag.
module mram_device_responder
  import mram_device_responder_pkg::*;
#(
  parameter int ADDR_WIDTH   = MRAM_ADDR_W,
  parameter int DEPTH_BITS   = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   chip_en,
  input  logic                   write_en,
  input  logic                   out_en,
  input  logic                   lower_byte_en,
  input  logic                   upper_byte_en,
  input  logic [ADDR_WIDTH-1:0]  addr,
  inout  wire  [MRAM_DATA_W-1:0] data,
  output logic                   rd_valid,
  output logic                   wr_commit,
  output logic                   timing_err
);

  localparam logic [3:0] LAT_M1 = 4'(READ_LATENCY - 1);

  state_t                 state, state_n;
  logic                   ce_q, we_q, oe_q;
  logic [1:0]             lane_q;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_lat, addr_lat_n;
  logic [MRAM_DATA_W-1:0] data_q, wdata_lat, wdata_lat_n, rd_word;
  logic [1:0]             wlane_lat, wlane_lat_n;
  logic [3:0]             cnt, cnt_n;
  logic                   commit, err_set, start_wr, start_rd, sel, addr_moved;
  logic                   read_ok, drive_lo, drive_hi;

  // Enables are kept in their active-low pin sense throughout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q   <= 1'b1;
      we_q   <= 1'b1;
      oe_q   <= 1'b1;
      lane_q <= 2'b11;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      ce_q   <= chip_en;
      we_q   <= write_en;
      oe_q   <= out_en;
      lane_q <= {upper_byte_en, lower_byte_en};
      addr_q <= addr;
      data_q <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr_lat   <= '0;
      wdata_lat  <= '0;
      wlane_lat  <= 2'b11;
      cnt        <= '0;
      timing_err <= 1'b0;
    end else begin
      state     <= state_n;
      addr_lat  <= addr_lat_n;
      wdata_lat <= wdata_lat_n;
      wlane_lat <= wlane_lat_n;
      cnt       <= cnt_n;
      if (err_set) timing_err <= 1'b1;
    end
  end

  assign sel        = !ce_q;
  assign addr_moved = (addr_q != addr_lat);

  // A write request always beats a pending or active read, as on the device.
  always_comb begin
    state_n     = state;
    addr_lat_n  = addr_lat;
    wdata_lat_n = wdata_lat;
    wlane_lat_n = wlane_lat;
    cnt_n       = cnt;
    commit      = 1'b0;
    err_set     = 1'b0;
    start_wr    = 1'b0;
    start_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !we_q)      start_wr = 1'b1;
        else if (sel && !oe_q) start_rd = 1'b1;
      end
      RD_WAIT: begin
        if (!sel || (we_q && oe_q)) state_n = IDLE;
        else if (!we_q)             start_wr = 1'b1;
        else if (addr_moved)        start_rd = 1'b1;
        else if (cnt == 4'd1)       state_n = RD_DRIVE;
        else                        cnt_n = cnt - 4'd1;
      end
      RD_DRIVE: begin
        if (!sel || (we_q && oe_q)) state_n = IDLE;
        else if (!we_q)             start_wr = 1'b1;
        else if (addr_moved)        start_rd = 1'b1;
        else if (lane_q == 2'b11)   err_set = 1'b1;
      end
      WR_ACTIVE: begin
        if (!sel || we_q) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          wdata_lat_n = data_q;
          wlane_lat_n = lane_q;
          if (addr_moved) err_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (start_wr) begin
      state_n     = WR_ACTIVE;
      addr_lat_n  = addr_q;
      wdata_lat_n = data_q;
      wlane_lat_n = lane_q;
    end
    if (start_rd) begin
      state_n    = (READ_LATENCY == 1) ? RD_DRIVE : RD_WAIT;
      addr_lat_n = addr_q;
      cnt_n      = LAT_M1;
    end
  end

  mram_device_responder_byte_array #(
    .DEPTH_BITS(DEPTH_BITS)
  ) u_array (
    .clk     (clk),
    .wr_addr (addr_lat[DEPTH_BITS-1:0]),
    .wr_lane (commit ? ~wlane_lat : 2'b00),
    .wr_data (wdata_lat),
    .rd_addr (addr_lat[DEPTH_BITS-1:0]),
    .rd_data (rd_word)
  );

  // Driver is gated by registered strobes so it lets go as soon as an exit is sampled.
  assign read_ok  = (state == RD_DRIVE) && sel && we_q && !oe_q && !addr_moved;
  assign drive_lo = read_ok && !lane_q[LANE_LO];
  assign drive_hi = read_ok && !lane_q[LANE_HI];

  assign data[7:0]  = drive_lo ? rd_word[7:0]  : 8'bz;
  assign data[15:8] = drive_hi ? rd_word[15:8] : 8'bz;

  assign rd_valid  = read_ok;
  assign wr_commit = commit;

endmodule
